// File: rtl/capture_thresh_pkg.sv
// Shared types and load_word field positions for the capture threshold loader.
package capture_thresh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_SWEEP  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int LD_BIT    = 31;
    localparam int CLR_BIT   = 30;
    localparam int CH_LSB    = 16;
    localparam int CH_FLD_W  = 12;
    localparam int TH_LSB    = 0;
    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/capture_strobe_edge.sv
// Two-bit rising-edge detector; the previous-value register resets to RST_LVL
// so a strobe that is already high when reset releases does not fire.
module capture_strobe_edge #(
    parameter logic [1:0] RST_LVL = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] strobe,
    output logic [1:0] rise
);

    logic [1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= RST_LVL;
        else     prev <= strobe;
    end

    assign rise = strobe & ~prev;

endmodule

// File: rtl/capture_thresh_load_ctrl.sv
// Sequences software threshold loads / clear sweeps into the threshold RAM.
// Optional feature: define CAPTURE_THRESH_CLAMP_EN to saturate single-load data.
module capture_thresh_load_ctrl
    import capture_thresh_pkg::*;
#(
    parameter int                    N_CH           = 256,
    parameter int                    CH_W           = 8,
    parameter int                    TH_W           = 16,
    parameter logic signed [TH_W-1:0] DEFAULT_THRESH = 16'sh8000,
    parameter logic signed [TH_W-1:0] TH_MIN         = -16'sd30000,
    parameter logic signed [TH_W-1:0] TH_MAX         = 16'sd0
) (
    input  logic                 OPB_Clk,
    input  logic                 OPB_Rst,
    input  logic [31:0]          load_word,
    input  logic                 thr_rdy,
    output logic                 thr_we,
    output logic [CH_W-1:0]      thr_addr,
    output logic [TH_W-1:0]      thr_data,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [31:0]             word_q;
    logic [1:0]              rise;
    logic                    ld_edge;
    logic                    clr_edge;
    logic [CH_FLD_W-1:0]     ch_fld;
    logic                    ch_ok;
    logic                    err_inc;
    state_t                  state;
    logic [CH_W-1:0]         addr_q;
    logic signed [TH_W-1:0]  data_q;

    function automatic logic signed [TH_W-1:0] clamp_th(input logic signed [TH_W-1:0] v);
`ifdef CAPTURE_THRESH_CLAMP_EN
        if (v < TH_MIN) return TH_MIN;
        if (v > TH_MAX) return TH_MAX;
        return v;
`else
        return v;
`endif
    endfunction

    always_ff @(posedge OPB_Clk) begin
        word_q <= load_word;
    end

    capture_strobe_edge #(
        .RST_LVL(2'b11)
    ) u_strobe_edge (
        .clk    (OPB_Clk),
        .rst    (OPB_Rst),
        .strobe ({word_q[LD_BIT], word_q[CLR_BIT]}),
        .rise   (rise)
    );

    assign ld_edge  = rise[1];
    assign clr_edge = rise[0];
    assign ch_fld   = word_q[CH_LSB +: CH_FLD_W];
    assign ch_ok    = ({1'b0, ch_fld} < (CH_FLD_W+1)'(N_CH));

    // Clear beats load on a tie, and every edge seen while busy is dropped.
    assign err_inc = (state != ST_IDLE) ? (ld_edge | clr_edge)
                                        : (ld_edge & (clr_edge | ~ch_ok));

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            done    <= 1'b0;
            err_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (clr_edge) begin
                        state  <= ST_SWEEP;
                        addr_q <= '0;
                        data_q <= DEFAULT_THRESH;
                    end else if (ld_edge && ch_ok) begin
                        state  <= ST_SINGLE;
                        addr_q <= ch_fld[CH_W-1:0];
                        data_q <= clamp_th(word_q[TH_LSB +: TH_W]);
                    end
                end
                ST_SINGLE: begin
                    if (thr_rdy) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    // The counter stops on the last entry rather than wrapping.
                    if (thr_rdy) begin
                        if (addr_q == CH_W'(N_CH - 1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign thr_we   = thr_rdy & ((state == ST_SINGLE) | (state == ST_SWEEP));
    assign thr_addr = addr_q;
    assign thr_data = data_q;

endmodule

// File: tb/tb_capture_thresh_load_ctrl.sv
// Directed self-checking bench for capture_thresh_load_ctrl (N_CH = 256).
module tb_capture_thresh_load_ctrl;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst = 1'b1;
    logic [31:0] load_word = 32'h0;
    logic        thr_rdy = 1'b1;
    logic        thr_we;
    logic [7:0]  thr_addr;
    logic [15:0] thr_data;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    capture_thresh_load_ctrl dut (
        .OPB_Clk  (OPB_Clk),
        .OPB_Rst  (OPB_Rst),
        .load_word(load_word),
        .thr_rdy  (thr_rdy),
        .thr_we   (thr_we),
        .thr_addr (thr_addr),
        .thr_data (thr_data),
        .busy     (busy),
        .done     (done),
        .err_cnt  (err_cnt)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge OPB_Clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int k;
        k = 0;
        while (busy === 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b still set after %0d cycles, required 0", name, busy, max_cyc);
        end
    endtask

    task automatic test_reset();
        OPB_Rst   = 1'b1;
        load_word = 32'hC000_0000;
        thr_rdy   = 1'b1;
        tick(4);
        checks++;
        if ({thr_we, busy, done, thr_addr, thr_data, err_cnt} !== 35'h0) begin
            errors++;
            $display("FAIL reset_vals: we=%b busy=%b done=%b addr=%h data=%h err=%0d, required all 0",
                     thr_we, busy, done, thr_addr, thr_data, err_cnt);
        end
        OPB_Rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (thr_we !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_no_trigger cyc%0d: we=%b busy=%b err=%0d, required 0/0/0",
                         i, thr_we, busy, err_cnt);
            end
        end
    endtask

    task automatic test_single(input string name, input logic [31:0] word,
                               input logic [7:0] exp_addr, input logic [15:0] exp_data);
        thr_rdy   = 1'b1;
        load_word = 32'h0;
        tick(3);
        load_word = word;
        tick();
        checks++;
        if (busy !== 1'b0 || thr_we !== 1'b0) begin
            errors++;
            $display("FAIL %s_cyc1: busy=%b we=%b, required 0/0", name, busy, thr_we);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || thr_we !== 1'b1 || thr_addr !== exp_addr || thr_data !== exp_data) begin
            errors++;
            $display("FAIL %s_cyc2: busy=%b we=%b addr=%h data=%h, required 1/1/%h/%h",
                     name, busy, thr_we, thr_addr, thr_data, exp_addr, exp_data);
        end
        tick();
        checks++;
        if (done !== 1'b1 || thr_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_cyc3: done=%b we=%b busy=%b, required 1/0/1", name, done, thr_we, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_cyc4: busy=%b done=%b, required 0/0", name, busy, done);
        end
        load_word = 32'h0;
        tick(2);
    endtask

    task automatic test_sweep_toggle();
        int exp_addr;
        int done_cnt;
        int cyc;
        load_word = 32'h0;
        thr_rdy   = 1'b1;
        tick(2);
        load_word = 32'h4000_0000;
        exp_addr  = 0;
        done_cnt  = 0;
        cyc       = 0;
        while (cyc < 1200 && !(done_cnt > 0 && busy === 1'b0)) begin
            @(posedge OPB_Clk);
            #1;
            thr_rdy = cyc[0];
            #1;
            if (thr_we === 1'b1) begin
                checks++;
                if (thr_addr !== exp_addr[7:0] || thr_data !== 16'h8000 || exp_addr > 255) begin
                    errors++;
                    $display("FAIL sweep_write#%0d: addr=%h data=%h, required %h/8000",
                             exp_addr, thr_addr, thr_data, exp_addr[7:0]);
                end
                exp_addr++;
            end
            if (done === 1'b1) done_cnt++;
            cyc++;
        end
        checks++;
        if (exp_addr != 256) begin
            errors++;
            $display("FAIL sweep_count: writes=%0d, required 256", exp_addr);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL sweep_done: done pulses=%0d, required 1", done_cnt);
        end
        thr_rdy = 1'b1;
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sweep_err: err_cnt=%0d, required 0", err_cnt);
        end
    endtask

    task automatic test_errors();
        thr_rdy   = 1'b1;
        load_word = 32'h0;
        tick(2);
        load_word = 32'h4000_0000;
        tick(10);
        load_word = 32'hC000_0000;
        tick(3);
        load_word = 32'h4000_0000;
        tick(2);
        checks++;
        if (err_cnt !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_busy_load: err=%0d busy=%b, required 1/1", err_cnt, busy);
        end
        wait_idle("err_sweep1_end", 400);
        load_word = 32'h0;
        tick(2);
        load_word = 32'hC000_0000;
        tick(3);
        checks++;
        if (err_cnt !== 8'd2 || busy !== 1'b1 || thr_data !== 16'h8000) begin
            errors++;
            $display("FAIL err_simul: err=%0d busy=%b data=%h, required 2/1/8000",
                     err_cnt, busy, thr_data);
        end
        wait_idle("err_sweep2_end", 400);
        load_word = 32'h0;
        tick(2);
        load_word = 32'h812C_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (thr_we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL err_badch cyc%0d: we=%b busy=%b, required 0/0", i, thr_we, busy);
            end
        end
        checks++;
        if (err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL err_badch_cnt: err=%0d, required 3", err_cnt);
        end
        load_word = 32'h0;
        tick(2);
    endtask

    task automatic test_reset_abort();
        int k;
        thr_rdy   = 1'b1;
        load_word = 32'h0;
        tick(2);
        load_word = 32'h4000_0000;
        k = 0;
        while (!(thr_we === 1'b1 && thr_addr === 8'd100) && k < 400) begin
            tick();
            k++;
        end
        checks++;
        if (thr_addr !== 8'd100) begin
            errors++;
            $display("FAIL abort_reach100: addr=%h, required 64", thr_addr);
        end
        OPB_Rst = 1'b1;
        tick();
        checks++;
        if (thr_we !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL abort_next: we=%b busy=%b err=%0d, required 0/0/0", thr_we, busy, err_cnt);
        end
        OPB_Rst = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_restart: busy=%b, required 0", busy);
        end
        load_word = 32'h0;
        tick(2);
        load_word = 32'h4000_0000;
        tick(2);
        checks++;
        if (thr_we !== 1'b1 || thr_addr !== 8'd0 || thr_data !== 16'h8000) begin
            errors++;
            $display("FAIL abort_restart: we=%b addr=%h data=%h, required 1/00/8000",
                     thr_we, thr_addr, thr_data);
        end
        wait_idle("abort_restart_end", 400);
    endtask

    initial begin
        test_reset();
        test_single("single_ch5", 32'h8005_FF00, 8'd5, 16'hFF00);
        test_sweep_toggle();
        test_errors();
`ifdef CAPTURE_THRESH_CLAMP_EN
        test_single("clamp_hi", 32'h8010_0100, 8'h10, 16'h0000);
        test_single("clamp_lo", 32'h80FF_8000, 8'hFF, 16'h8AD0);
`else
        test_single("verbatim_pos", 32'h8010_0100, 8'h10, 16'h0100);
        test_single("verbatim_neg", 32'h80FF_8000, 8'hFF, 16'h8000);
`endif
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
